// File: rtl/hm_sched_pkg.sv
// Shared types and defaults for the hash job scheduler.
package hm_sched_pkg;

   localparam int DEF_NUM_REQ  = 4;
   localparam int DEF_BUDGET_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      RUN,
      FOUND,
      HOLD,
      RELEASE,
      EXHAUST,
      ABORT
   } sched_state_t;

endpackage

// File: rtl/hash_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer.
module rr_arbiter
   import hm_sched_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [$clog2(NUM_REQ)-1:0] idx,
   output logic                       any
);

   localparam int IDX_W = $clog2(NUM_REQ);

   assign any = |req;

   // Scan from the farthest offset down so the nearest requester wins.
   always_comb begin
      idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % NUM_REQ])
            idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
      end
      gnt      = '0;
      gnt[idx] = any;
   end

endmodule

// File: rtl/hash_job_scheduler.sv
// Shares one hashing module among NUM_REQ requesters, one budgeted job at a time.
module hash_job_scheduler
   import hm_sched_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int BUDGET_W = DEF_BUDGET_W
) (
   input  logic                        clk,
   input  logic                        n_rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [BUDGET_W-1:0]         budget,
   input  logic                        hash_done,
   input  logic                        valid_hash_flag,
   output logic [NUM_REQ-1:0]          grant,
   output logic [$clog2(NUM_REQ)-1:0]  owner,
   output logic                        begin_hash,
   output logic                        quit_hash,
   output logic                        job_found,
   output logic                        job_exhausted,
   output logic                        job_aborted,
   output logic [BUDGET_W-1:0]         attempts
);

   localparam int IDX_W = $clog2(NUM_REQ);

   sched_state_t         state;
   logic [IDX_W-1:0]     ptr;
   logic [IDX_W-1:0]     arb_idx;
   logic [NUM_REQ-1:0]   arb_gnt;
   logic                 arb_any;
   logic [BUDGET_W-1:0]  budget_q;
   logic [BUDGET_W-1:0]  att_inc;
   logic                 hd_q;
   logic                 hd_edge;
   logic                 own_req;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
      return (int'(i) == NUM_REQ - 1) ? '0 : i + IDX_W'(1);
   endfunction

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req (req),
      .ptr (ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   assign hd_edge = hash_done & ~hd_q;
   // grant is held through START/RUN/HOLD, so it selects the owner's request bit.
   assign own_req = |(req & grant);
   assign att_inc = attempts + BUDGET_W'(1);

   always_ff @(posedge clk) begin
      if (state == IDLE && arb_any)
         budget_q <= budget;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state         <= IDLE;
         ptr           <= '0;
         grant         <= '0;
         owner         <= '0;
         begin_hash    <= 1'b0;
         quit_hash     <= 1'b0;
         job_found     <= 1'b0;
         job_exhausted <= 1'b0;
         job_aborted   <= 1'b0;
         attempts      <= '0;
         hd_q          <= 1'b0;
      end else begin
         begin_hash    <= 1'b0;
         quit_hash     <= 1'b0;
         job_found     <= 1'b0;
         job_exhausted <= 1'b0;
         job_aborted   <= 1'b0;
         hd_q          <= hash_done;
         case (state)
            IDLE: begin
               if (arb_any) begin
                  owner    <= arb_idx;
                  attempts <= '0;
                  if (budget == '0) begin
                     state         <= EXHAUST;
                     quit_hash     <= 1'b1;
                     job_exhausted <= 1'b1;
                     ptr           <= wrap_inc(arb_idx);
                  end else begin
                     state      <= START;
                     grant      <= arb_gnt;
                     begin_hash <= 1'b1;
                  end
               end
            end
            START: begin
               hd_q <= 1'b0;
               if (!own_req) begin
                  state       <= ABORT;
                  quit_hash   <= 1'b1;
                  job_aborted <= 1'b1;
                  grant       <= '0;
                  ptr         <= wrap_inc(owner);
               end else begin
                  state <= RUN;
               end
            end
            RUN: begin
               // A withdrawn request takes precedence over a coincident attempt edge.
               if (!own_req) begin
                  state       <= ABORT;
                  quit_hash   <= 1'b1;
                  job_aborted <= 1'b1;
                  grant       <= '0;
                  ptr         <= wrap_inc(owner);
               end else if (hd_edge) begin
                  attempts <= att_inc;
                  if (valid_hash_flag) begin
                     state     <= FOUND;
                     job_found <= 1'b1;
                  end else if (att_inc == budget_q) begin
                     state         <= EXHAUST;
                     quit_hash     <= 1'b1;
                     job_exhausted <= 1'b1;
                     grant         <= '0;
                     ptr           <= wrap_inc(owner);
                  end
               end
            end
            FOUND: state <= HOLD;
            HOLD: begin
               if (!own_req) begin
                  state     <= RELEASE;
                  quit_hash <= 1'b1;
                  grant     <= '0;
                  ptr       <= wrap_inc(owner);
               end
            end
            RELEASE, EXHAUST, ABORT: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/hash_job_scheduler.md
# hash_job_scheduler

Shares the single hashing module among `NUM_REQ` mining requesters. Grants one requester at a time in round-robin order and drives the hash controller's `begin_hash` / `quit_hash` controls. Counts hash attempts against a per-job budget and reports found, exhausted or aborted to the granted requester. Sits between the requester front-ends and the hashing module controller.

## Interface
- `NUM_REQ`, 4, number of requesters (2–8)
- `BUDGET_W`, 16, width of attempt budget and counter

- `clk`  in  1  system clock
- `n_rst`  in  1  reset; one clock, reset is asynchronous and active-low
- `req`  in  NUM_REQ  per-requester job pending; level, held until job ends
- `budget`  in  BUDGET_W  max attempts, sampled at grant
- `hash_done`  in  1  from hash controller; high during check/hold
- `valid_hash_flag`  in  1  from hash checker; qualifies `hash_done`
- `grant`  out  NUM_REQ  one-hot owner, held for whole job
- `owner`  out  $clog2(NUM_REQ)  index of granted requester
- `begin_hash`  out  1  one-cycle start pulse to hash controller
- `quit_hash`  out  1  one-cycle stop pulse to hash controller
- `job_found`  out  1  one-cycle pulse, valid hash found
- `job_exhausted`  out  1  one-cycle pulse, budget used up
- `job_aborted`  out  1  one-cycle pulse, owner withdrew `req`
- `attempts`  out  BUDGET_W  completed attempts in current job

## Operation
- **Reset:** all outputs 0, state IDLE, RR pointer = 0, so requester 0 has highest priority first.
- **IDLE:** if any `req` bit is set, the round-robin arbiter picks the first set bit at or after the pointer. Latch `owner`, `grant`, and `budget`; clear `attempts`.
  - If latched budget == 0 → EXHAUST with no `begin_hash`.
  - Otherwise → START.
- **START:** `begin_hash` = 1 for one cycle; clear the edge-detect register → RUN.
- **RUN:** an attempt completes on a rising edge of `hash_done` (registered compare). On that cycle, `attempts` += 1.
  - If `valid_hash_flag` → FOUND.
  - Else if new `attempts` == budget → EXHAUST.
  - Else stay; the hash controller auto-increments and restarts.
- **FOUND:** `job_found` pulse → HOLD. The hash module holds its result.
- **HOLD:** `grant` is held until `req[owner]` = 0, then → RELEASE.
- **RELEASE:** `quit_hash` pulse, `grant` = 0 → IDLE.
- **EXHAUST:** `quit_hash` pulse, `job_exhausted` pulse, `grant` = 0 → IDLE.
- **Abort:** `req[owner]` = 0 in START or RUN → ABORT: `quit_hash` pulse, `job_aborted` pulse, `grant` = 0 → IDLE.
- **RR pointer:** on every job end (RELEASE / EXHAUST / ABORT), pointer = `owner` + 1 mod NUM_REQ. A requester still holding `req` is re-granted only after the others have been served.
- **Simultaneous events:**
  - Abort and attempt edge in the same cycle: abort wins; no `job_found`; `attempts` not incremented.
  - Valid hash on the final budgeted attempt: FOUND wins over EXHAUST.
- **Outputs:** `attempts` saturates at budget; it is held after job end until the next grant. `req` changes of non-owners are ignored during a job.

## Timing
- All outputs are registered, Moore-style from state; no combinational input→output paths.
- Cycle 0: IDLE samples `req`. Cycle 1: START, `grant`/`owner` valid, `begin_hash` = 1. Cycle 2: RUN.
- Attempt edge at cycle n (RUN): `attempts` updates at n+1; `job_found` / `job_exhausted` is high at n+1.
- `quit_hash` is high exactly one cycle. IDLE always takes at least one cycle before the next START, giving ≥2 cycles between `quit_hash` and the next `begin_hash`.
- `grant` is never zero-to-different-owner in one step; it always passes through an all-zero cycle.
- Reset asserted mid-job: outputs go to 0 immediately (async). No `quit_hash` is issued; the hash controller shares `n_rst`.

## Structure
- Package `hm_sched_pkg`:
  - `sched_state_t` enum: IDLE, START, RUN, FOUND, HOLD, RELEASE, EXHAUST, ABORT
  - default `NUM_REQ` and `BUDGET_W` localparams
- Sub-module `rr_arbiter`: combinational, inputs `req` and pointer, outputs one-hot grant, index and `any`. Instantiated once.
- The top holds the FSM, budget/attempt registers, `hash_done` edge register and RR pointer.

## Test plan
- Single requester, `req`=0001, `budget`=3, never valid → `begin_hash` at cycle 1, then 3 `hash_done` edges → `job_exhausted`, `quit_hash`, `attempts`=3, `grant`=0.
- `req`=0010, `valid_hash_flag` on attempt 2 → `job_found`, `attempts`=2. `grant` held until `req` drops, then `quit_hash` next cycle.
- `req`=1111 held, `budget`=1 → grants in order 0,1,2,3,0; each separated by an all-zero `grant` cycle.
- `budget`=0 → `job_exhausted` and `quit_hash` with no `begin_hash`; `attempts`=0.
- Owner drops `req` on the same cycle as a valid `hash_done` edge → `job_aborted` only; no `job_found`; `attempts` unchanged.
- `n_rst` low during RUN → all outputs 0 that cycle; after release, `req`=0100 is granted with the pointer starting at 0.
